// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU sequencer/arbiter (alu_seq_ctrl).
//   - Request opcodes: OP_AND..OP_PASS map 1:1 onto the ALU select code,
//     OP_MUL is the sequenced multiply, anything above is illegal.
//   - ALU select codes used by the sequencer itself (ADD for MUL steps,
//     PASS as the idle drive).
//   - Controller state type.
// Optional feature macro: ALU_SEQ_MUL_EN (see alu_seq_ctrl).
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_INC  = 4'd5;
    localparam logic [3:0] OP_DEC  = 4'd6;
    localparam logic [3:0] OP_PASS = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;

    localparam logic [2:0] ALU_SEL_ADD  = 3'b010;
    localparam logic [2:0] ALU_SEL_PASS = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } state_t;

    // Opcodes 0000..0111 go straight to the ALU select.
    function automatic logic is_native(input logic [3:0] op);
        return !op[3];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant: picks the first asserted valid bit
// searching upward from ptr, wrapping modulo NREQ. The pointer register lives
// in the parent.
// Ports:
//   ptr       in   IW    search start index
//   valid     in   NREQ  request vector
//   grant     out  NREQ  one-hot grant (all zero when nothing is valid)
//   grant_idx out  IW    index of the granted requester
//   any       out  1     at least one valid request
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [IW-1:0]   ptr,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    always_comb begin
        int s;
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        grant_idx = '0;
        any       = 1'b0;
        // Walk from the farthest candidate back to ptr so the nearest valid
        // requester is the last (winning) assignment -- no break needed.
        for (int k = NREQ - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= NREQ) s = s - NREQ;
            if (valid[s]) begin
                grant_idx = IW'(s);
                any       = 1'b1;
            end
        end
        grant = any ? (NREQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Shares one W-bit combinational ALU between NREQ requesters. A round-robin
// arbiter picks a requester in IDLE, the op runs for one cycle (EXEC) or as
// repeated ADDs (MUL), and the registered result is offered on a single
// response channel (RESP) until consumed.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   per-requester handshake (ready one-hot, IDLE only)
//   req_op/req_a/req_b    packed per-requester opcode and operands
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_data       served requester index and result
//   rsp_zero/rsp_err      result-is-zero flag, illegal-opcode flag
//   alu_sel/alu_a/alu_b   drive to the ALU
//   alu_out               ALU result (combinational)
//   busy                  controller not in IDLE
// Optional feature macro: ALU_SEQ_MUL_EN -- when defined, opcode 1000 is a
// multi-cycle multiply; when undefined it is treated as illegal and the MUL
// state, accumulator and counter are not built.
// -----------------------------------------------------------------------------
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 8,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [4*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IW-1:0]   rsp_id,
    output logic [W-1:0]    rsp_data,
    output logic            rsp_zero,
    output logic            rsp_err,
    output logic [2:0]      alu_sel,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    input  logic [W-1:0]    alu_out,
    output logic            busy
);

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr, grant_idx;
    logic [NREQ-1:0] grant;
    logic            any_valid, accept;
    logic [3:0]      in_op;
    logic [W-1:0]    in_a, in_b;

    logic [3:0]      op_q;
    logic [W-1:0]    a_q, b_q, result_q;
    logic [IW-1:0]   id_q;
    logic            err_q, zero_q;
`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0]    acc_q, cnt_q;
`endif

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .ptr       (rr_ptr),
        .valid     (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_valid)
    );

    assign in_op  = req_op[4*grant_idx +: 4];
    assign in_a   = req_a[W*grant_idx +: W];
    assign in_b   = req_b[W*grant_idx +: W];
    // req_ready is the grant in IDLE, so a valid grant is itself the accept.
    assign accept = (state == IDLE) && any_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        // NOTE: non-blocking assignment in clocked blocks so every register
        // samples the pre-edge values regardless of statement order.
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    state_nxt = (in_op == OP_MUL) ? MUL : EXEC;
`else
                    state_nxt = EXEC;
`endif
                end
            end
            EXEC: state_nxt = RESP;
`ifdef ALU_SEQ_MUL_EN
            MUL:  if (cnt_q == '0) state_nxt = RESP;
`endif
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (state == IDLE) ? grant : '0;
        busy      = (state != IDLE);
        rsp_valid = (state == RESP);
        alu_sel   = ALU_SEL_PASS;
        alu_a     = '0;
        alu_b     = '0;
        if (state == EXEC && is_native(op_q)) begin
            alu_sel = op_q[2:0];
            alu_a   = a_q;
            alu_b   = b_q;
        end
`ifdef ALU_SEQ_MUL_EN
        if (state == MUL && cnt_q != '0) begin
            alu_sel = ALU_SEL_ADD;
            alu_a   = acc_q;
            alu_b   = a_q;
        end
`endif
    end

    assign rsp_id   = id_q;
    assign rsp_data = result_q;
    assign rsp_zero = zero_q;
    assign rsp_err  = err_q;

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand/result registers are reset as well, because
            // they drive rsp_* directly and those must read zero out of reset.
            rr_ptr   <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= in_op;
                        a_q    <= in_a;
                        b_q    <= in_b;
                        id_q   <= grant_idx;
                        rr_ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
`ifdef ALU_SEQ_MUL_EN
                        acc_q  <= '0;
                        cnt_q  <= in_b;
`endif
                    end
                end
                EXEC: begin
                    if (is_native(op_q)) begin
                        result_q <= alu_out;
                        err_q    <= 1'b0;
                        zero_q   <= (alu_out == '0);
                    end else begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        zero_q   <= 1'b1;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    if (cnt_q != '0) begin
                        acc_q <= alu_out;
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        result_q <= acc_q;
                        err_q    <= 1'b0;
                        zero_q   <= (acc_q == '0);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Self-checking bench for alu_seq_ctrl (NREQ=2, W=8) with a behavioural ALU.
// Accepted requests push an expected response (data, flags, id, latency)
// onto a scoreboard; responses pop and compare. Grant order is checked
// against an independent round-robin pointer. Honours ALU_SEQ_MUL_EN.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;

    localparam int NREQ = 2;
    localparam int W    = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [4*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a, req_b;
    logic            rsp_valid, rsp_ready;
    logic [0:0]      rsp_id;
    logic [W-1:0]    rsp_data;
    logic            rsp_zero, rsp_err;
    logic [2:0]      alu_sel;
    logic [W-1:0]    alu_a, alu_b, alu_out;
    logic            busy;

    alu_seq_ctrl #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        case (alu_sel)
            3'd0: alu_out = alu_a & alu_b;
            3'd1: alu_out = alu_a | alu_b;
            3'd2: alu_out = alu_a + alu_b;
            3'd3: alu_out = alu_a - alu_b;
            3'd4: alu_out = ~alu_a;
            3'd5: alu_out = alu_a + 8'd1;
            3'd6: alu_out = alu_a - 8'd1;
            default: alu_out = alu_a;
        endcase
    end

    typedef struct {
        logic [31:0] id;
        logic [7:0]  data;
        logic        zero;
        logic        err;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0, n_miss = 0;
    int cyc = 0, acc_count = 0, rsp_count = 0;
    int first_cyc = 0, exp_ptr = 0;
    bit seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [15:0] p;
        e.id = 0; e.data = 8'h00; e.err = 1'b0; e.lat = 2; e.acc_cyc = 0;
        p = 16'h0;
        case (op)
            4'd0: e.data = a & b;
            4'd1: e.data = a | b;
            4'd2: e.data = a + b;
            4'd3: e.data = a - b;
            4'd4: e.data = ~a;
            4'd5: e.data = a + 8'd1;
            4'd6: e.data = a - 8'd1;
            4'd7: e.data = a;
`ifdef ALU_SEQ_MUL_EN
            4'd8: begin
                p = {8'd0, a} * {8'd0, b};
                e.data = p[7:0];
                e.lat  = 2 + int'(b);
            end
`endif
            default: e.err = 1'b1;
        endcase
        e.zero = (e.data == 8'h00);
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard monitor: accepts push, responses pop.
    always @(negedge clk) begin
        exp_t e;
        int idx, eg;
        bit found;
        if (!rst_n) begin
            sb.delete();
            seen    = 0;
            exp_ptr = 0;
        end else begin
            check("rdy_onehot", 32'($countones(req_ready) <= 1), 1);
            if (|(req_valid & req_ready)) begin
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) idx = i;
                eg = 0; found = 0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req_valid[(exp_ptr + k) % NREQ]) begin
                        eg = (exp_ptr + k) % NREQ;
                        found = 1;
                    end
                end
                check("grant", idx, eg);
                e = model(req_op[4*idx +: 4], req_a[8*idx +: 8], req_b[8*idx +: 8]);
                e.id = idx;
                e.acc_cyc = cyc;
                sb.push_back(e);
                exp_ptr = (eg + 1) % NREQ;
                acc_count++;
            end
            if (rsp_valid && !seen) begin
                seen = 1;
                first_cyc = cyc;
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id",   rsp_id,   e.id);
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_zero", rsp_zero, e.zero);
                    check("rsp_err",  rsp_err,  e.err);
                    check("latency",  first_cyc - e.acc_cyc, e.lat);
                end
                seen = 0;
                rsp_count++;
            end
        end
    end

    task automatic drive(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[4*i +: 4] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
        req_valid[i]     = 1'b1;
    endtask

    task automatic wait_acc(input int a0);
        bit ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(posedge clk); #1;
            if (acc_count > a0) ok = 1;
        end
        check("accept_wait", ok, 1);
    endtask

    task automatic wait_rsp(input int r0);
        bit ok = 0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(posedge clk); #1;
            if (rsp_count >= r0) ok = 1;
        end
        check("rsp_wait", ok, 1);
    endtask

    task automatic run_one(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int a0, r0;
        a0 = acc_count;
        r0 = rsp_count;
        drive(i, op, a, b);
        wait_acc(a0);
        req_valid[i] = 1'b0;
        wait_rsp(r0 + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, r0;
        bit ok;
        rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1;

        // Reset state
        #12;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy",      busy,      0);
        check("rst_rsp_data",  rsp_data,  0);
        check("rst_rsp_id",    rsp_id,    0);
        check("rst_rsp_zero",  rsp_zero,  0);
        check("rst_rsp_err",   rsp_err,   0);
        check("rst_alu_sel",   alu_sel,   3'b111);
        check("rst_alu_ab",    {alu_a, alu_b}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Native ops
        run_one(0, 4'b0010, 8'h05, 8'h03);  // ADD 08
        run_one(0, 4'b0011, 8'h03, 8'h03);  // SUB 00, zero
        run_one(1, 4'b0110, 8'h00, 8'h00);  // DEC wrap FF
        run_one(1, 4'b0000, 8'hF0, 8'h3C);  // AND
        run_one(0, 4'b0001, 8'hA0, 8'h05);  // OR
        run_one(1, 4'b0100, 8'h5A, 8'h00);  // NOT
        run_one(0, 4'b0101, 8'hFF, 8'h00);  // INC wrap 00

        // Round-robin with both requesters continuously valid
        r0 = rsp_count;
        drive(0, 4'b0111, 8'h00, 8'h00);
        drive(1, 4'b0111, 8'h01, 8'h00);
        wait_rsp(r0 + 4);
        req_valid = '0;
        wait_rsp(r0 + 4);

        // MUL (illegal when the feature is not built)
        run_one(0, 4'b1000, 8'h07, 8'h06);  // 2A
        run_one(1, 4'b1000, 8'h09, 8'h00);  // 00
        run_one(0, 4'b1000, 8'h20, 8'h10);  // 200 -> 00
        run_one(1, 4'b1000, 8'hFF, 8'hFF);  // FE01 -> 01

        // Illegal op with a stalled consumer and a pending second requester
        rsp_ready = 1'b0;
        a0 = acc_count; r0 = rsp_count;
        drive(0, 4'b1101, 8'h12, 8'h34);
        wait_acc(a0);
        req_valid[0] = 1'b0;
        drive(1, 4'b0111, 8'h55, 8'h00);
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) ok = 1;
        end
        check("stall_rsp_seen", ok, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("stall_valid",     rsp_valid, 1);
            check("stall_data",      rsp_data,  0);
            check("stall_err",       rsp_err,   1);
            check("stall_zero",      rsp_zero,  1);
            check("stall_id",        rsp_id,    0);
            check("stall_req_ready", req_ready, 0);
            check("stall_alu_sel",   alu_sel,   3'b111);
        end
        rsp_ready = 1'b1;
        wait_acc(a0 + 1);
        req_valid[1] = 1'b0;
        wait_rsp(r0 + 2);

        // Reset in the middle of a transaction from requester 0
        rsp_ready = 1'b0;
        a0 = acc_count;
        drive(0, 4'b1000, 8'h07, 8'h06);
        wait_acc(a0);
        req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_valid",     rsp_valid, 0);
        check("mid_rst_busy",      busy,      0);
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_alu_sel",   alu_sel,   3'b111);
        check("mid_rst_alu_ab",    {alu_a, alu_b}, 0);
        check("mid_rst_data",      rsp_data,  0);
        check("mid_rst_err",       rsp_err,   0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("post_rst_no_rsp", rsp_valid, 0);
        end
        r0 = rsp_count;
        drive(0, 4'b0111, 8'h00, 8'h00);
        drive(1, 4'b0111, 8'h01, 8'h00);
        wait_rsp(r0 + 1);
        req_valid = '0;
        wait_rsp(r0 + 1);
        repeat (4) @(posedge clk);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
